// File: rtl/la_oajoin222.sv
// Three-channel redundant-source join: each channel picks one of two requesters
// (round-robin when both are valid), and the joined word lands in a registered output stage.

module la_oajoin222_chan #(
  parameter int DW = 8
) (
  input  logic [1:0]      valid,
  input  logic [2*DW-1:0] data,
  input  logic            ptr,
  input  logic            load,
  output logic            sel,
  output logic [1:0]      ready,
  output logic [DW-1:0]   word
);
  // When only one requester is valid it wins outright; the pointer arbitrates only when both are valid.
  assign sel   = (&valid) ? ptr : valid[1];
  assign ready = {load & sel, load & ~sel};
  assign word  = sel ? data[2*DW-1:DW] : data[DW-1:0];
endmodule

module la_oajoin222 #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15,
  parameter     PROP    = "DEFAULT"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      a_valid,
  input  logic [2*DW-1:0] a_data,
  output logic [1:0]      a_ready,
  input  logic [1:0]      b_valid,
  input  logic [2*DW-1:0] b_data,
  output logic [1:0]      b_ready,
  input  logic [1:0]      c_valid,
  input  logic [2*DW-1:0] c_data,
  output logic [1:0]      c_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3*DW-1:0] out_data,
  output logic [2:0]      out_src,
  output logic            stall
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [2:0][1:0]      ch_valid;
  logic [2:0][1:0]      ch_ready;
  logic [2:0][2*DW-1:0] ch_data;
  logic [2:0][DW-1:0]   word;
  logic [2:0]           ptr;
  logic [2:0]           sel;
  logic                 join_ok;
  logic                 any_valid;
  logic                 load;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;

  // PROP is an implementation hint only; it selects nothing.
  if ($bits(PROP) == 0) begin : g_prop
  end

  assign ch_valid = {c_valid, b_valid, a_valid};
  assign ch_data  = {c_data, b_data, a_data};
  assign {c_ready, b_ready, a_ready} = ch_ready;

  assign join_ok   = (|a_valid) & (|b_valid) & (|c_valid);
  assign any_valid = |ch_valid;
  // Gated by reset so no requester sees an accept during the reset cycle.
  assign load      = ~reset & join_ok & (~out_valid | out_ready);

  for (genvar i = 0; i < 3; i++) begin : g_ch
    la_oajoin222_chan #(.DW(DW)) u_chan (
      .valid (ch_valid[i]),
      .data  (ch_data[i]),
      .ptr   (ptr[i]),
      .load  (load),
      .sel   (sel[i]),
      .ready (ch_ready[i]),
      .word  (word[i])
    );
  end

  // Saturating starvation counter; back-pressure with a full join also counts.
  always_comb begin
    cnt_nxt = cnt;
    if (load | ~any_valid)          cnt_nxt = '0;
    else if (cnt < CW'(TIMEOUT))    cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
      cnt       <= '0;
      stall     <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word;
        out_src   <= sel;
        ptr       <= ~sel;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      cnt   <= cnt_nxt;
      stall <= (cnt_nxt == CW'(TIMEOUT));
    end
  end
endmodule
